// File: rtl/ghost_pkg.sv
// ghost_pkg: definitions shared by the ghost mode sequencer and the ghost movers.
//   - one-hot mode codes driven onto the mover's mode input
//   - sequencer state type whose encoding is the one-hot mode itself
//   - direction codes used by the movers
//   - schedule helpers: phase reload length and the schedule mode for a phase
package ghost_pkg;

    localparam logic [3:0] MODE_CHASE   = 4'b1000;
    localparam logic [3:0] MODE_SCATTER = 4'b0100;
    localparam logic [3:0] MODE_FRIGHT  = 4'b0010;
    localparam logic [3:0] MODE_EATEN   = 4'b0001;

    // State encoding equals the mode code, so the mode output is the state register.
    typedef enum logic [3:0] {
        ST_CHASE   = MODE_CHASE,
        ST_SCATTER = MODE_SCATTER,
        ST_FRIGHT  = MODE_FRIGHT,
        ST_EATEN   = MODE_EATEN
    } ghost_state_t;

    localparam logic [1:0] LEFT  = 2'd0;
    localparam logic [1:0] RIGHT = 2'd1;
    localparam logic [1:0] UP    = 2'd2;
    localparam logic [1:0] DOWN  = 2'd3;

    // Move count loaded when the schedule enters phase ph. Phase 7 is the
    // unbounded chase and never reloads, so its value is irrelevant.
    function automatic int unsigned phase_reload(input logic [2:0]  ph,
                                                 input int unsigned scatter_l,
                                                 input int unsigned scatter_s,
                                                 input int unsigned chase);
        case (ph)
            3'd1, 3'd3, 3'd5: return chase;
            3'd2:             return scatter_l;
            3'd4, 3'd6:       return scatter_s;
            3'd0:             return scatter_l;
            default:          return 0;
        endcase
    endfunction

    // Even phases scatter, odd phases chase.
    function automatic ghost_state_t sched_mode(input logic [2:0] ph);
        return ph[0] ? ST_CHASE : ST_SCATTER;
    endfunction

endpackage

// File: rtl/move_pacer.sv
// move_pacer: paces ghost moves.
//   A free-running cycle counter (gated by run) marks one move boundary every
//   MOVE_PERIOD cycles; a registered update window follows each boundary for
//   UPDATE_LEN cycles. Dropping run freezes the counter and aborts the window.
// Ports:
//   sysclk    in   clock
//   resetn    in   async active-low reset
//   run       in   1 = pacing active
//   boundary  out  combinational strobe, run & cnt==MOVE_PERIOD-1
//   update    out  registered move window
module move_pacer #(
    parameter int MOVE_PERIOD = 64,
    parameter int UPDATE_LEN  = 8
) (
    input  logic sysclk,
    input  logic resetn,
    input  logic run,
    output logic boundary,
    output logic update
);

    localparam int CW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int LW = $clog2(UPDATE_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_PERIOD - 1);

    logic [CW-1:0] cnt;
    logic [LW-1:0] rem;   // window cycles left, including the current one

    assign boundary = run && (cnt == CNT_LAST);

    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            rem    <= '0;
            update <= 1'b0;
        end else begin
            if (run)
                cnt <= boundary ? '0 : cnt + CW'(1);

            if (boundary) begin
                rem    <= LW'(UPDATE_LEN);
                update <= 1'b1;
            end else if (!run) begin
                rem    <= '0;
                update <= 1'b0;
            end else if (rem != '0) begin
                rem    <= rem - LW'(1);
                update <= (rem > LW'(1));
            end
        end
    end

endmodule

// File: rtl/ghost_mode_sequencer.sv
// ghost_mode_sequencer: per-ghost upstream controller for a ghost mover.
//   Paces moves (move_pacer), runs the scatter/chase schedule, enters
//   frightened on energizer, eaten on capture, and returns to the schedule
//   when the ghost reaches the house. All mode/rotate/phase/timer changes
//   happen on a move boundary, so they are stable across the update window.
// Ports:
//   sysclk       in   clock
//   resetn       in   async active-low reset
//   run          in   1 = game running, 0 = freeze pacing and timers
//   energizer    in   pulse: energizer eaten
//   ghost_eaten  in   pulse: this ghost captured
//   ghost_home   in   pulse: this ghost reached the house
//   mode         out  one-hot 1000 chase, 0100 scatter, 0010 frightened, 0001 eaten
//   rotate       out  reversal request for the coming move
//   update       out  move window
//   phase        out  schedule phase 0..7
module ghost_mode_sequencer
    import ghost_pkg::*;
#(
    parameter int MOVE_PERIOD     = 64,
    parameter int UPDATE_LEN      = 8,
    parameter int SCATTER_L_MOVES = 56,
    parameter int SCATTER_S_MOVES = 40,
    parameter int CHASE_MOVES     = 160,
    parameter int FRIGHT_MOVES    = 48,
    parameter int TW              = 12
) (
    input  logic       sysclk,
    input  logic       resetn,
    input  logic       run,
    input  logic       energizer,
    input  logic       ghost_eaten,
    input  logic       ghost_home,
    output logic [3:0] mode,
    output logic       rotate,
    output logic       update,
    output logic [2:0] phase
);

    localparam logic [TW-1:0] SCHED_INIT  = TW'(SCATTER_L_MOVES);
    localparam logic [TW-1:0] FRIGHT_INIT = TW'(FRIGHT_MOVES);
    localparam logic [TW-1:0] ONE         = TW'(1);

    logic boundary;

    move_pacer #(
        .MOVE_PERIOD (MOVE_PERIOD),
        .UPDATE_LEN  (UPDATE_LEN)
    ) u_pacer (
        .sysclk   (sysclk),
        .resetn   (resetn),
        .run      (run),
        .boundary (boundary),
        .update   (update)
    );

    ghost_state_t  state_q, state_d;
    logic          rot_q, rot_d;
    logic [2:0]    phase_q, phase_d, phase_nx;
    logic [TW-1:0] sched_q, sched_d;
    logic [TW-1:0] fright_q, fright_d;
    logic          pend_e, pend_g, pend_h;
    logic          ev_e, ev_g, ev_h;

    // A pulse landing on the boundary cycle itself is folded into that
    // boundary's decision rather than being lost by the flag clear.
    assign ev_e = pend_e | energizer;
    assign ev_g = pend_g | ghost_eaten;
    assign ev_h = pend_h | ghost_home;

    assign phase_nx = phase_q + 3'd1;

    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            pend_e <= 1'b0;
            pend_g <= 1'b0;
            pend_h <= 1'b0;
        end else if (boundary) begin
            pend_e <= 1'b0;
            pend_g <= 1'b0;
            pend_h <= 1'b0;
        end else begin
            pend_e <= ev_e;
            pend_g <= ev_g;
            pend_h <= ev_h;
        end
    end

    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_SCATTER;
            rot_q    <= 1'b0;
            phase_q  <= 3'd0;
            sched_q  <= SCHED_INIT;
            fright_q <= '0;
        end else begin
            state_q  <= state_d;
            rot_q    <= rot_d;
            phase_q  <= phase_d;
            sched_q  <= sched_d;
            fright_q <= fright_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rot_d    = rot_q;
        phase_d  = phase_q;
        sched_d  = sched_q;
        fright_d = fright_q;

        if (boundary) begin
            rot_d = 1'b0;
            if (state_q == ST_EATEN && ev_h) begin
                state_d = sched_mode(phase_q);
            end else if (state_q == ST_FRIGHT && ev_g) begin
                // Capture wins over a same-window energizer.
                state_d  = ST_EATEN;
                fright_d = '0;
            end else if (ev_e && state_q != ST_EATEN) begin
                // A repeat energizer only refreshes the timer; no second reversal.
                state_d  = ST_FRIGHT;
                fright_d = FRIGHT_INIT;
                rot_d    = (state_q != ST_FRIGHT);
            end else if (state_q == ST_FRIGHT) begin
                if (fright_q <= ONE) begin
                    state_d  = sched_mode(phase_q);
                    fright_d = '0;
                end else begin
                    fright_d = fright_q - ONE;
                end
            end else if (state_q == ST_SCATTER || state_q == ST_CHASE) begin
                // Phase 7 is the final unbounded chase: schedule timer holds.
                if (phase_q != 3'd7) begin
                    if (sched_q == ONE) begin
                        phase_d = phase_nx;
                        sched_d = TW'(phase_reload(phase_nx, SCATTER_L_MOVES,
                                                   SCATTER_S_MOVES, CHASE_MOVES));
                        state_d = sched_mode(phase_nx);
                        rot_d   = 1'b1;
                    end else if (sched_q != '0) begin
                        sched_d = sched_q - ONE;
                    end
                end
            end
        end
    end

    assign mode   = state_q;
    assign rotate = rot_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_ghost_mode_sequencer.sv
// Directed bench for ghost_mode_sequencer with small schedule parameters.
// Outputs are sampled on the falling clock edge; after a reset release at a
// falling edge, each 10 falling edges lands on the first cycle of the next
// update window.
module tb_ghost_mode_sequencer;

    localparam logic [3:0] M_CH = 4'b1000;
    localparam logic [3:0] M_SC = 4'b0100;
    localparam logic [3:0] M_FR = 4'b0010;
    localparam logic [3:0] M_EA = 4'b0001;

    logic       sysclk = 1'b0;
    logic       resetn = 1'b0;
    logic       run = 1'b0;
    logic       energizer = 1'b0;
    logic       ghost_eaten = 1'b0;
    logic       ghost_home = 1'b0;
    logic [3:0] mode;
    logic       rotate;
    logic       update;
    logic [2:0] phase;

    int n_checks = 0;
    int n_errors = 0;

    ghost_mode_sequencer #(
        .MOVE_PERIOD     (10),
        .UPDATE_LEN      (7),
        .SCATTER_L_MOVES (3),
        .SCATTER_S_MOVES (2),
        .CHASE_MOVES     (4),
        .FRIGHT_MOVES    (3),
        .TW              (12)
    ) dut (
        .sysclk      (sysclk),
        .resetn      (resetn),
        .run         (run),
        .energizer   (energizer),
        .ghost_eaten (ghost_eaten),
        .ghost_home  (ghost_home),
        .mode        (mode),
        .rotate      (rotate),
        .update      (update),
        .phase       (phase)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; run = 1'b0;
        energizer = 1'b0; ghost_eaten = 1'b0; ghost_home = 1'b0;
        cyc(2);
        resetn = 1'b1; run = 1'b1;
    endtask

    // Holds the given pulses for one cycle (consumes one falling edge).
    task automatic pulse(input logic e, input logic g, input logic h);
        energizer = e; ghost_eaten = g; ghost_home = h;
        cyc(1);
        energizer = 1'b0; ghost_eaten = 1'b0; ghost_home = 1'b0;
    endtask

    task automatic chk_win(input string tag, input logic [3:0] m, input logic [2:0] ph, input logic rot);
        chk({tag, "_mode"},   32'(mode),   32'(m));
        chk({tag, "_phase"},  32'(phase),  32'(ph));
        chk({tag, "_rotate"}, 32'(rotate), 32'(rot));
        chk({tag, "_update"}, 32'(update), 32'd1);
    endtask

    initial begin
        int ends[7];
        int ph;
        logic rot;
        ends = '{3, 7, 10, 14, 16, 20, 22};

        // 1: reset values and window timing
        do_reset();
        chk("t1_rst_mode",   32'(mode),   32'(M_SC));
        chk("t1_rst_rotate", 32'(rotate), 32'd0);
        chk("t1_rst_phase",  32'(phase),  32'd0);
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("t1_update_%0d", k), 32'(update), 32'((k >= 10) && ((k % 10) < 7)));
            cyc(1);
        end

        // 2: free-running schedule, phase ends after boundaries 3,7,10,14,16,20,22
        do_reset();
        for (int b = 1; b <= 26; b++) begin
            cyc(10);
            ph  = 0;
            rot = 1'b0;
            for (int i = 0; i < 7; i++) begin
                if (ends[i] <= b) ph++;
                if (ends[i] == b) rot = 1'b1;
            end
            chk_win($sformatf("t2_b%0d", b), ph[0] ? M_CH : M_SC, 3'(ph), rot);
        end

        // 3: energizer in chase, phase 1 with two moves left
        do_reset();
        cyc(50);
        chk_win("t3_w5", M_CH, 3'd1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        cyc(9);
        chk_win("t3_w6", M_FR, 3'd1, 1'b1);
        cyc(10); chk_win("t3_w7",  M_FR, 3'd1, 1'b0);
        cyc(10); chk_win("t3_w8",  M_FR, 3'd1, 1'b0);
        cyc(10); chk_win("t3_w9",  M_CH, 3'd1, 1'b0);
        cyc(10); chk_win("t3_w10", M_CH, 3'd1, 1'b0);
        cyc(10); chk_win("t3_w11", M_SC, 3'd2, 1'b1);

        // 4: energizer + capture together while frightened, then home
        do_reset();
        cyc(10); chk_win("t4_w1", M_SC, 3'd0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0); cyc(9);
        chk_win("t4_w2", M_FR, 3'd0, 1'b1);
        pulse(1'b1, 1'b1, 1'b0); cyc(9);
        chk_win("t4_w3", M_EA, 3'd0, 1'b0);
        cyc(10); chk_win("t4_w4", M_EA, 3'd0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1); cyc(9);
        chk_win("t4_w5", M_SC, 3'd0, 1'b0);
        cyc(10); chk_win("t4_w6", M_SC, 3'd0, 1'b0);
        cyc(10); chk_win("t4_w7", M_CH, 3'd1, 1'b1);

        // 5: ignored events (capture in scatter, energizer in eaten, home in scatter)
        do_reset();
        cyc(10);
        pulse(1'b0, 1'b1, 1'b0); cyc(9);
        chk_win("t5_w2", M_SC, 3'd0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0); cyc(9);
        chk_win("t5_w3", M_FR, 3'd0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0); cyc(9);
        chk_win("t5_w4", M_EA, 3'd0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0); cyc(9);
        chk_win("t5_w5", M_EA, 3'd0, 1'b0);
        cyc(10); chk_win("t5_w6", M_EA, 3'd0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1); cyc(9);
        chk_win("t5_w7", M_SC, 3'd0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1); cyc(9);
        chk_win("t5_w8", M_CH, 3'd1, 1'b1);

        // 6: async reset mid-window, then run=0 mid-window
        do_reset();
        cyc(30);
        chk_win("t6_w3", M_CH, 3'd1, 1'b1);
        cyc(2);
        chk("t6_c3_update", 32'(update), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_update", 32'(update), 32'd0);
        chk("t6_rst_mode",   32'(mode),   32'(M_SC));
        chk("t6_rst_rotate", 32'(rotate), 32'd0);
        chk("t6_rst_phase",  32'(phase),  32'd0);
        @(negedge sysclk);
        resetn = 1'b1; run = 1'b1;
        cyc(9);
        chk("t6_pre_update", 32'(update), 32'd0);
        cyc(1);
        chk_win("t6_w1", M_SC, 3'd0, 1'b0);
        cyc(1);
        chk("t6_c2_update", 32'(update), 32'd1);
        run = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        chk("t6_abort_update", 32'(update), 32'd0);
        cyc(4);
        chk("t6_frozen_update", 32'(update), 32'd0);
        chk("t6_frozen_mode",   32'(mode),   32'(M_SC));
        run = 1'b1;
        cyc(8);
        chk("t6_resume_update", 32'(update), 32'd0);
        cyc(1);
        chk_win("t6_w2", M_FR, 3'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
